// File: rtl/serial_add_ctrl_if.sv
// Command/result bundle between an add requester and the bit-serial adder controller.
// The requester drives start and operands; the controller returns status and the sum.
interface serial_add_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;

    modport master (
        output start, op_a, op_b,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_a, op_b,
        output busy, done, result, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-add per clock, LSB first, built from two half adders.
// The controller owns operand/sum shift registers, carry, bit counter and handshake.
module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;
endmodule

module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    serial_add_ctrl_if.slave      add_if
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sreg_a_q, sreg_a_d;
    logic [WIDTH-1:0] sreg_b_q, sreg_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic s0, c0, s, c1, c;

    half_adder u_ha0 (
        .a_i (sreg_a_q[0]),
        .b_i (sreg_b_q[0]),
        .s_o (s0),
        .c_o (c0)
    );

    half_adder u_ha1 (
        .a_i (s0),
        .b_i (carry_q),
        .s_o (s),
        .c_o (c1)
    );

    assign c = c0 | c1;

    always_comb begin
        state_d  = state_q;
        sreg_a_d = sreg_a_q;
        sreg_b_d = sreg_b_q;
        sum_d    = sum_q;
        result_d = result_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (add_if.start) begin
                    sreg_a_d = add_if.op_a;
                    sreg_b_d = add_if.op_b;
                    carry_d  = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                sum_d    = {s, sum_q[WIDTH-1:1]};
                sreg_a_d = {1'b0, sreg_a_q[WIDTH-1:1]};
                sreg_b_d = {1'b0, sreg_b_q[WIDTH-1:1]};
                carry_d  = c;
                if (cnt_q == CntLast) begin
                    // Final bit: publish the sum and park the counter instead of wrapping.
                    result_d = {s, sum_q[WIDTH-1:1]};
                    cout_d   = c;
                    cnt_d    = '0;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            sreg_a_q <= '0;
            sreg_b_q <= '0;
            sum_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sreg_a_q <= sreg_a_d;
            sreg_b_q <= sreg_b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign add_if.busy   = (state_q == StRun);
    assign add_if.done   = (state_q == StDone);
    assign add_if.result = result_q;
    assign add_if.cout   = cout_q;
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: adds two WIDTH-bit operands with a single 1-bit full-add datapath, one bit per clock, LSB first.
- The 1-bit datapath is built from two half_adder instances plus an OR for carry-out.
- The controller owns the operand shift registers, the carry register, the bit counter and the start/done handshake.
- Sits between a requester issuing add commands and the shared 1-bit adder resource.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled on rising CLK only in IDLE.
- OP_A  input  WIDTH  operand A; captured on the accepted START edge.
- OP_B  input  WIDTH  operand B; captured on the accepted START edge.
- BUSY  output  1  high while in RUN.
- DONE  output  1  one-cycle pulse; high while in DONE_S.
- RESULT  output  WIDTH  sum bits [WIDTH-1:0] of the last completed add.
- COUT  output  1  carry-out of the last completed add.

Behaviour:
- Reset (RST_N low, asynchronous, any state):
  - state=IDLE.
  - BUSY=0, DONE=0, RESULT=0, COUT=0.
  - Shift registers, carry register and counter all cleared.
  - Takes effect immediately, without waiting for a clock edge.
  - Any add in progress is abandoned: no DONE, RESULT keeps its reset value.
- FSM states: IDLE, RUN, DONE_S.
- IDLE, START=1 at edge k:
  - sreg_a<=OP_A, sreg_b<=OP_B, carry<=0, cnt<=0, state<=RUN.
  - BUSY=1 from after edge k.
- IDLE, START=0: remain in IDLE.
- RUN, each edge:
  - Datapath computes s = sreg_a[0]^sreg_b[0]^carry and c = majority(sreg_a[0], sreg_b[0], carry).
  - sum_sreg <= {s, sum_sreg[WIDTH-1:1]}.
  - sreg_a and sreg_b shift right by 1.
  - carry<=c, cnt<=cnt+1.
- RUN exit:
  - At the edge where cnt==WIDTH-1, i.e. edge k+WIDTH, the final bit is processed.
  - On that edge: RESULT<={s, sum_sreg[WIDTH-1:1]}, COUT<=c, state<=DONE_S, BUSY<=0, DONE<=1.
- DONE_S:
  - Lasts exactly one cycle; next edge state<=IDLE, DONE<=0.
  - START during DONE_S is ignored (not queued).
- Latency: DONE is high during the cycle after edge k+WIDTH.
  - First possible re-accept is edge k+WIDTH+2.
  - Throughput: one add per WIDTH+2 cycles.
- START during RUN is ignored; OP_A/OP_B changes after capture have no effect.
- RESULT/COUT:
  - Update only on entry to DONE_S.
  - Hold their value through IDLE and the whole of the next RUN.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; COUT = bit WIDTH of OP_A+OP_B.
  - {COUT,RESULT} == OP_A+OP_B exactly.
- Counter: $clog2(WIDTH) bits; never wraps, because RUN exits at WIDTH-1.
- BUSY and DONE are never high simultaneously.

Test Plan:
- Reset (WIDTH=8): drive RST_N=0 mid-cycle, no clock edge -> BUSY=0, DONE=0, RESULT=0x00, COUT=0 immediately.
- 0x05+0x03: START one cycle -> BUSY high 8 cycles, DONE pulse 1 cycle, RESULT=0x08, COUT=0; RESULT holds 0x08 ten cycles later.
- Full carry ripple, 0xFF+0x01 -> RESULT=0x00, COUT=1; 0xFF+0xFF -> RESULT=0xFE, COUT=1.
- START held high throughout, first operands 0x12+0x34, OP_A/OP_B changed to 0x77/0x77 during RUN:
  - First DONE gives RESULT=0x46.
  - START ignored during DONE_S.
  - Next add accepted exactly at edge k+10 with 0x77+0x77 -> RESULT=0xEE, COUT=0.
- Reset mid-operation: start 0x0F+0x01, assert RST_N=0 after 4 RUN cycles -> no DONE, RESULT=0x00. Release, then start 0xA5+0x5A -> RESULT=0xFF, COUT=0.
- Self-check sweep: 200 random OP_A/OP_B pairs, back-to-back -> {COUT,RESULT}==OP_A+OP_B every DONE pulse; DONE&BUSY never 1.
